// File: rtl/stream_packet_rx.sv
// Packet-write receiver: frames sop/eop words into a FIFO and only
// exposes a packet to the consumer once its eop word has been accepted.
module stream_packet_rx #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int MAX_PKT = 8
) (
    input  logic                     clk_hifreq,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wren,
    input  logic                     sop,
    input  logic                     eop,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     rdy,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        data_out,
    output logic                     out_sop,
    output logic                     out_eop,
    input  logic                     rd_en,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     drop_err,
    output logic                     ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_PKT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DISCARD
    } state_t;

    logic [DATA_W+1:0] mem [DEPTH];

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   wr_ptr_n;
    logic [PW-1:0]   commit_ptr;
    logic [PW-1:0]   commit_ptr_n;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   waddr;
    logic [PW-1:0]   base;
    logic [LW-1:0]   pkt_len;
    logic [LW-1:0]   pkt_len_n;
    logic            acc;
    logic            pop;
    logic            we;
    logic            commit;
    logic            drop;
    logic            start;

    assign used      = wr_ptr - rd_ptr;
    assign rdy       = en & ~rst & (used < PW'(DEPTH));
    assign acc       = wren & rdy;
    assign out_valid = (rd_ptr != commit_ptr);
    assign pop       = rd_en & out_valid;

    assign {out_sop, out_eop, data_out} = mem[rd_ptr[AW-1:0]];

    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        pkt_len_n    = pkt_len;
        waddr        = wr_ptr;
        base         = wr_ptr;
        we           = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;
        start        = 1'b0;

        if (acc) begin
            unique case (state)
                IDLE: begin
                    if (sop) start = 1'b1;
                    else     drop  = 1'b1;
                end
                IN_PKT: begin
                    if (sop) begin
                        // restart over the abandoned partial packet
                        drop  = 1'b1;
                        start = 1'b1;
                        base  = commit_ptr;
                    end else if (eop) begin
                        we           = 1'b1;
                        wr_ptr_n     = wr_ptr + 1'b1;
                        commit       = 1'b1;
                        commit_ptr_n = wr_ptr + 1'b1;
                        state_n      = IDLE;
                    end else if (pkt_len < LW'(MAX_PKT - 1)) begin
                        we        = 1'b1;
                        wr_ptr_n  = wr_ptr + 1'b1;
                        pkt_len_n = pkt_len + 1'b1;
                    end else begin
                        wr_ptr_n = commit_ptr;
                        drop     = 1'b1;
                        state_n  = DISCARD;
                    end
                end
                DISCARD: begin
                    if (sop)      start   = 1'b1;
                    else if (eop) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        if (start) begin
            we       = 1'b1;
            waddr    = base;
            wr_ptr_n = base + 1'b1;
            if (eop) begin
                commit       = 1'b1;
                commit_ptr_n = base + 1'b1;
                state_n      = IDLE;
            end else begin
                pkt_len_n = LW'(1);
                state_n   = IN_PKT;
            end
        end
    end

    always_ff @(posedge clk_hifreq) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_len    <= '0;
            pkt_count  <= '0;
            drop_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            commit_ptr <= commit_ptr_n;
            pkt_len    <= pkt_len_n;
            drop_err   <= drop;
            ovf_err    <= wren & ~rdy;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({commit, pop & out_eop})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge clk_hifreq) begin
        if (we) mem[waddr[AW-1:0]] <= {sop, eop, data_in};
    end

endmodule

// File: tb/tb_stream_packet_rx.sv
// Bench for stream_packet_rx: directed packet scenarios plus random
// traffic, checked against a queue-based packet model.
module tb_stream_packet_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int MAXP  = 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk_hifreq = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wren = 1'b0;
    logic          sop = 1'b0;
    logic          eop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic          rdy;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic          out_sop;
    logic          out_eop;
    logic [PW-1:0] pkt_count;
    logic [PW-1:0] used;
    logic          drop_err;
    logic          ovf_err;

    stream_packet_rx #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_PKT(MAXP)) dut (
        .clk_hifreq(clk_hifreq),
        .rst(rst),
        .en(en),
        .wren(wren),
        .sop(sop),
        .eop(eop),
        .data_in(data_in),
        .rdy(rdy),
        .out_valid(out_valid),
        .data_out(data_out),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .rd_en(rd_en),
        .pkt_count(pkt_count),
        .used(used),
        .drop_err(drop_err),
        .ovf_err(ovf_err)
    );

    always #5 clk_hifreq = ~clk_hifreq;

    typedef struct packed {
        logic          s;
        logic          e;
        logic [DW-1:0] d;
    } word_t;

    // committed words visible to the consumer, and the packet being built
    word_t comq[$];
    word_t cur[$];
    bit    discarding;
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (comq[i]) if (comq[i].e) n++;
        return n;
    endfunction

    function automatic void model_commit();
        foreach (cur[i]) comq.push_back(cur[i]);
        cur.delete();
    endfunction

    task automatic step(input bit w, input bit s, input bit e,
                        input logic [DW-1:0] d, input bit en_i, input bit rd);
        int    u;
        bit    r;
        bit    acc;
        bit    dexp;
        bit    oexp;
        word_t wd;
        wren = w; sop = s; eop = e; data_in = d; en = en_i; rd_en = rd;
        #1;
        u = comq.size() + cur.size();
        r = en_i && (u < DEPTH);
        chk("rdy", 64'(rdy), 64'(r));
        chk("used", 64'(used), 64'(u));
        chk("pkt_count", 64'(pkt_count), 64'(model_pkts()));
        chk("out_valid", 64'(out_valid), 64'(comq.size() > 0));
        if (comq.size() > 0)
            chk("head", 64'({out_sop, out_eop, data_out}), 64'(comq[0]));
        acc  = w && r;
        dexp = 1'b0;
        oexp = w && !r;
        if (rd && comq.size() > 0) void'(comq.pop_front());
        if (acc) begin
            wd = {s, e, d};
            if (s) begin
                if (cur.size() > 0) dexp = 1'b1;
                cur.delete();
                discarding = 1'b0;
                cur.push_back(wd);
                if (e) model_commit();
            end else if (discarding) begin
                if (e) discarding = 1'b0;
            end else if (cur.size() == 0) begin
                dexp = 1'b1;
            end else if (e) begin
                cur.push_back(wd);
                model_commit();
            end else if (cur.size() < MAXP - 1) begin
                cur.push_back(wd);
            end else begin
                cur.delete();
                dexp = 1'b1;
                discarding = 1'b1;
            end
        end
        @(posedge clk_hifreq);
        #1;
        chk("drop_err", 64'(drop_err), 64'(dexp));
        chk("ovf_err", 64'(ovf_err), 64'(oexp));
    endtask

    task automatic send(input bit s, input bit e, input logic [DW-1:0] d);
        step(1'b1, s, e, d, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; wren = 1'b0; rd_en = 1'b0;
        #1;
        chk("rst_rdy", 64'(rdy), 64'(0));
        @(posedge clk_hifreq);
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_used", 64'(used), 64'(0));
        chk("rst_pkts", 64'(pkt_count), 64'(0));
        chk("rst_drop", 64'(drop_err), 64'(0));
        chk("rst_ovf", 64'(ovf_err), 64'(0));
        rst = 1'b0;
        comq.delete();
        cur.delete();
        discarding = 1'b0;
    endtask

    initial begin
        @(posedge clk_hifreq);
        #1;
        do_reset();

        send(1, 1, 32'hA5);
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_data", 64'(data_out), 64'h0000_00A5);
        chk("t1_tags", 64'({out_sop, out_eop}), 64'h3);
        chk("t1_pkts", 64'(pkt_count), 64'(1));
        drain(2);

        send(1, 0, 32'h10);
        send(0, 0, 32'h11);
        send(0, 0, 32'h12);
        chk("t2_hidden", 64'(out_valid), 64'(0));
        send(0, 1, 32'h13);
        drain(5);

        send(1, 0, 32'h1);
        send(0, 0, 32'h2);
        send(1, 0, 32'h7);
        send(0, 0, 32'h8);
        send(0, 1, 32'h9);
        chk("t3_used", 64'(used), 64'(3));
        drain(4);

        send(1, 0, 32'h20);
        for (int i = 1; i < 8; i++) send(0, 0, 32'h20 + i);
        send(0, 1, 32'h28);
        chk("t4_empty", 64'(used), 64'(0));
        send(1, 0, 32'h30);
        send(0, 1, 32'h31);
        drain(3);

        for (int p = 0; p < 2; p++) begin
            send(1, 0, 32'h40 + 16 * p);
            for (int i = 1; i < 7; i++) send(0, 0, 32'h40 + 16 * p + i);
            send(0, 1, 32'h47 + 16 * p);
        end
        chk("t5_full", 64'(rdy), 64'(0));
        send(1, 1, 32'hEE);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("t5_recover", 64'(rdy), 64'(1));
        drain(17);

        send(1, 0, 32'h50);
        step(1'b1, 1'b0, 1'b0, 32'h51, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        send(0, 1, 32'h52);
        drain(3);

        send(1, 1, 32'h60);
        send(1, 0, 32'h61);
        send(0, 1, 32'h62);
        send(1, 0, 32'h63);
        do_reset();
        send(1, 0, 32'h70);
        send(0, 1, 32'h71);
        drain(3);

        for (int i = 0; i < 1500; i++) begin
            int rdp;
            if (i == 700) do_reset();
            rdp = ((i / 150) % 2 == 0) ? 70 : 20;
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 92,
                 $urandom_range(0, 99) < rdp);
        end
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
